// File: rtl/psram_pkg.sv
// Shared types and default timing for the PSRAM arbiter.
// Imported by the arbiter top and its wait counter.
package psram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN
  } psram_state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } psram_gnt_t;

  localparam int DEF_T_WR       = 3;
  localparam int DEF_T_RD       = 4;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/psram_wait_cnt.sv
// Loadable down-counter with terminal flag.
// Times the ACCESS phase of both reads and writes.
module psram_wait_cnt
  import psram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter and strobe sequencer for the
// pair of asynchronous PSRAM chips.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int T_WR       = DEF_T_WR,
  parameter int T_RD       = DEF_T_RD,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              CLK50,
  input  logic              MSS_RESET_N,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-2:0] psram_address,
  output logic              psram_ncs0,
  output logic              psram_ncs1,
  output logic              psram_noe0,
  output logic              psram_noe1,
  output logic              psram_nwe,
  output logic [1:0]        psram_nbyte_en,
  output logic [DATA_W-1:0] psram_data_o,
  output logic              psram_data_oe,
  input  logic [DATA_W-1:0] psram_data_i,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SMAX  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(T_RD - 1);

  psram_state_t     state_q, state_nx;
  psram_gnt_t       win_q, f_win;
  logic             we_q, chip_q;
  logic [1:0]       be_q, f_be;
  logic [CNT_W-1:0] starve_q;
  logic             idle, grant_a, grant_b;
  logic             f_we, f_chip;
  logic             cs_act, acc, done;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  psram_wait_cnt u_wait (
    .clk      (CLK50),
    .rst_n    (MSS_RESET_N),
    .load     (state_q == S_SETUP),
    .load_val (we_q ? WR_LD : RD_LD),
    .en       (state_q == S_ACCESS),
    .done     (done)
  );

  always_comb begin
    idle     = (state_q == S_IDLE);
    grant_a  = idle && a_req &&
               !(b_req && starve_q == SMAX);
    grant_b  = idle && b_req && !grant_a;
    sel_addr = grant_a ? a_addr : b_addr;
    sel_data = grant_a ? a_wdata : b_wdata;
    // Pad values are registered, so in IDLE they
    // must look at the winner, not the latches.
    f_win  = idle ? (grant_a ? GNT_A : GNT_B) : win_q;
    f_we   = idle ? (grant_a | b_we) : we_q;
    f_chip = idle ? sel_addr[ADDR_W-1] : chip_q;
    f_be   = idle ? (grant_a ? 2'b11 : b_be) : be_q;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE:
        if (grant_a || grant_b) state_nx = S_SETUP;
      S_SETUP:
        state_nx = S_ACCESS;
      S_ACCESS:
        if (done) state_nx = we_q ? S_HOLD : S_TURN;
      S_HOLD:
        state_nx = S_IDLE;
      S_TURN:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
    cs_act = (state_nx == S_SETUP) ||
             (state_nx == S_ACCESS) ||
             (state_nx == S_HOLD);
    acc    = (state_nx == S_ACCESS);
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q <= S_IDLE;
      win_q   <= GNT_A;
      we_q    <= 1'b0;
      chip_q  <= 1'b0;
      be_q    <= 2'b11;
    end else begin
      state_q <= state_nx;
      if (grant_a || grant_b) begin
        win_q  <= f_win;
        we_q   <= f_we;
        chip_q <= f_chip;
        be_q   <= f_be;
      end
    end
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      starve_q <= '0;
    end else if (!b_req || grant_b) begin
      starve_q <= '0;
    end else if (grant_a && starve_q != SMAX) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      psram_address  <= '0;
      psram_data_o   <= '0;
      psram_ncs0     <= 1'b1;
      psram_ncs1     <= 1'b1;
      psram_noe0     <= 1'b1;
      psram_noe1     <= 1'b1;
      psram_nwe      <= 1'b1;
      psram_nbyte_en <= 2'b11;
      psram_data_oe  <= 1'b0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      busy           <= 1'b0;
      b_rdata        <= '0;
    end else begin
      if (grant_a || grant_b) begin
        psram_address <= sel_addr[ADDR_W-2:0];
        psram_data_o  <= sel_data;
      end
      psram_ncs0     <= !(cs_act && !f_chip);
      psram_ncs1     <= !(cs_act && f_chip);
      psram_noe0     <= !(acc && !f_we && !f_chip);
      psram_noe1     <= !(acc && !f_we && f_chip);
      psram_nwe      <= !(acc && f_we);
      psram_nbyte_en <= cs_act ? ~f_be : 2'b11;
      psram_data_oe  <= cs_act && f_we;
      a_ack <= (state_nx == S_HOLD) && (f_win == GNT_A);
      b_ack <= ((state_nx == S_HOLD) && (f_win == GNT_B)) ||
               (state_nx == S_TURN);
      busy  <= (state_nx != S_IDLE);
      if (state_q == S_ACCESS && done && !we_q) begin
        b_rdata <= psram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter:
// vector table per transaction plus corner sequences.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0;
  logic [22:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ack;
  logic        b_req = 1'b0;
  logic        b_we = 1'b0;
  logic [1:0]  b_be = 2'b11;
  logic [22:0] b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic [21:0] address;
  logic        ncs0, ncs1, noe0, noe1, nwe;
  logic [1:0]  nbe;
  logic [15:0] data_o, data_i;
  logic        data_oe, busy;

  int errors = 0;
  int checks = 0;
  logic both_low = 1'b0;

  psram_arbiter dut (
    .CLK50          (clk),
    .MSS_RESET_N    (rst_n),
    .a_req          (a_req),
    .a_addr         (a_addr),
    .a_wdata        (a_wdata),
    .a_ack          (a_ack),
    .b_req          (b_req),
    .b_we           (b_we),
    .b_be           (b_be),
    .b_addr         (b_addr),
    .b_wdata        (b_wdata),
    .b_ack          (b_ack),
    .b_rdata        (b_rdata),
    .psram_address  (address),
    .psram_ncs0     (ncs0),
    .psram_ncs1     (ncs1),
    .psram_noe0     (noe0),
    .psram_noe1     (noe1),
    .psram_nwe      (nwe),
    .psram_nbyte_en (nbe),
    .psram_data_o   (data_o),
    .psram_data_oe  (data_oe),
    .psram_data_i   (data_i),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Memory model: chip 0 always returns C0DE,
  // chip 1 returns 1234 only at word 0x20.
  assign data_i = !noe0 ? 16'hC0DE :
                  (!noe1 && address == 22'h000020) ? 16'h1234 :
                  16'hDEAD;

  always @(negedge clk)
    if (!ncs0 && !ncs1) both_low = 1'b1;

  typedef struct {
    string       name;
    logic        src_b;
    logic        we;
    logic [1:0]  be;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        chip;
    int          acc_hi;
    int          cs_hi;
    int          ack;
    logic [1:0]  nbe;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    logic cs_low, ac;
    logic [10:0] exp, act;
    @(posedge clk); #1;
    if (t.src_b) begin
      b_req = 1'b1; b_we = t.we; b_be = t.be;
      b_addr = t.addr; b_wdata = t.wdata;
    end else begin
      a_req = 1'b1; a_addr = t.addr; a_wdata = t.wdata;
    end
    for (int c = 1; c <= t.ack + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      cs_low = (c <= t.cs_hi);
      ac     = (c >= 2) && (c <= t.acc_hi);
      exp = {!(cs_low && !t.chip), !(cs_low && t.chip),
             !(ac && !t.we && !t.chip), !(ac && !t.we && t.chip),
             !(ac && t.we), t.we && cs_low,
             cs_low ? t.nbe : 2'b11,
             (c == t.ack) && !t.src_b, (c == t.ack) && t.src_b,
             c <= t.ack};
      act = {ncs0, ncs1, noe0, noe1, nwe, data_oe, nbe,
             a_ack, b_ack, busy};
      chk($sformatf("%s_c%0d", t.name, c), 32'(act), 32'(exp));
      if (cs_low)
        chk($sformatf("%s_addr_c%0d", t.name, c),
            32'(address), 32'(t.addr[21:0]));
      if (t.we && cs_low)
        chk($sformatf("%s_data_c%0d", t.name, c),
            32'(data_o), 32'(t.wdata));
      if (!t.we && c == t.ack)
        chk($sformatf("%s_rdata", t.name),
            32'(b_rdata), 32'(t.rdata));
      if (a_ack || b_ack) begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string order;
    int n, guard, max_st, acks;
    logic seen;

    vecs[0] = '{"cap_wr", 1'b0, 1'b1, 2'b11, 23'h000010,
                16'hBEEF, 1'b0, 4, 5, 5, 2'b00, 16'h0};
    vecs[1] = '{"host_rd1", 1'b1, 1'b0, 2'b11, 23'h400020,
                16'h0, 1'b1, 5, 5, 6, 2'b00, 16'h1234};
    vecs[2] = '{"host_bw", 1'b1, 1'b1, 2'b10, 23'h000100,
                16'hAB00, 1'b0, 4, 5, 5, 2'b01, 16'h0};
    vecs[3] = '{"host_bw1", 1'b1, 1'b1, 2'b01, 23'h7FFFFF,
                16'h00CD, 1'b1, 4, 5, 5, 2'b10, 16'h0};
    vecs[4] = '{"host_rd0", 1'b1, 1'b0, 2'b11, 23'h000020,
                16'h0, 1'b0, 5, 5, 6, 2'b00, 16'hC0DE};

    repeat (2) @(negedge clk);
    chk("reset_pads", 32'({ncs0, ncs1, noe0, noe1, nwe, data_oe,
        nbe, a_ack, b_ack, busy}), 32'(11'b111110_11_000));
    chk("reset_rdata", 32'(b_rdata), 32'h0);
    chk("reset_addr", 32'(address), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a write access.
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 23'h000040; a_wdata = 16'h5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_nwe", 32'(nwe), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_pads", 32'({ncs0, ncs1, noe0, noe1, nwe,
        data_oe, busy, a_ack, b_ack}), 32'(9'b11111_0_0_00));
    chk("rst_mid_data", 32'({address, data_o}), 32'h0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    chk("rst_no_ack", 32'(acks), 32'h0);
    chk("rst_idle", 32'(busy), 32'h0);

    // Starvation: both requesters held high.
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 23'h000010; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b11;
    b_addr = 23'h000200; b_wdata = 16'h2222;
    order = ""; n = 0; guard = 0; max_st = 0;
    while (n < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (int'(dut.starve_q) > max_st) max_st = int'(dut.starve_q);
      if (a_ack) begin order = {order, "A"}; n++; end
      if (b_ack) begin order = {order, "B"}; n++; end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("starve_timeout", 32'(guard >= 200), 32'h0);
    checks++;
    if (order != "AAAABAAAAB") begin
      errors++;
      $display("FAIL starve_order: got %s want AAAABAAAAB", order);
    end
    chk("starve_max", 32'(max_st > 4), 32'h0);
    repeat (3) @(negedge clk);

    // Read on chip 1 followed at once by a capture write.
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_be = 2'b11; b_addr = 23'h400020;
    seen = 1'b0; guard = 0;
    while (!seen && guard < 12) begin
      @(negedge clk);
      guard++;
      if (b_ack) seen = 1'b1;
    end
    chk("turn_ack_seen", 32'(seen), 32'h1);
    b_req = 1'b0;
    a_req = 1'b1; a_addr = 23'h000030; a_wdata = 16'h7777;
    chk("turn_pads", 32'({data_oe, noe0, noe1, ncs0, ncs1}),
        32'(5'b0_1111));
    chk("turn_rdata", 32'(b_rdata), 32'h1234);
    @(negedge clk);
    chk("turn_idle", 32'({data_oe, busy}), 32'h0);
    @(negedge clk);
    chk("turn_setup", 32'({data_oe, ncs0, ncs1, nwe, noe0, noe1}),
        32'(6'b1_0_1_111));
    seen = 1'b0; guard = 0;
    while (!seen && guard < 12) begin
      @(negedge clk);
      guard++;
      if (a_ack) seen = 1'b1;
    end
    a_req = 1'b0;
    chk("turn_wr_ack", 32'(seen), 32'h1);
    chk("turn_hold_rdata", 32'(b_rdata), 32'h1234);

    repeat (2) @(negedge clk);
    chk("cs_exclusive", 32'(both_low), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Shares the two external asynchronous PSRAM chips between the pixel-capture write stream and the MSS/APB host port. Arbitrates single-word requests, sequences chip select, output-enable, write-enable and byte-lane strobes with parameterised wait states, and returns read data and completion pulses. Sits between the capture FIFO drain logic, the APB slave, and the top-level `psram_*` pads; it also drives `TP_BUSY`.

## Interface
- `ADDR_W`, 23: word address width; MSB selects the chip (0 → `ncs0`, 1 → `ncs1`).
- `DATA_W`, 16: PSRAM data width.
- `T_WR`, 3: write ACCESS cycles (`nwe` low); legal range 1..15.
- `T_RD`, 4: read ACCESS cycles (`noe` low); legal range 1..15.
- `STARVE_MAX`, 4: consecutive capture grants allowed while host waits; legal range 1..15.

Ports:
- `CLK50` in 1: single clock.
- `MSS_RESET_N` in 1: asynchronous, active-low reset.
- `a_req` in 1: capture write request (level).
- `a_addr` in ADDR_W: capture word address.
- `a_wdata` in DATA_W: capture write data.
- `a_ack` out 1: one-cycle pulse, capture write complete.
- `b_req` in 1: host request (level).
- `b_we` in 1: host write (1) or read (0).
- `b_be` in 2: host byte enables, active-high.
- `b_addr` in ADDR_W: host word address.
- `b_wdata` in DATA_W: host write data.
- `b_ack` out 1: one-cycle pulse, host access complete.
- `b_rdata` out DATA_W: read data; valid while `b_ack`=1 after a read, held until the next host read.
- `psram_address` out ADDR_W-1: chip word address.
- `psram_ncs0`, `psram_ncs1` out 1: chip selects, active-low.
- `psram_noe0`, `psram_noe1` out 1: output enables, active-low, per chip.
- `psram_nwe` out 1: write enable, active-low, shared.
- `psram_nbyte_en` out 2: byte lanes, active-low.
- `psram_data_o` out DATA_W, `psram_data_oe` out 1, `psram_data_i` in DATA_W: tristate split; the top level builds the `psram_data` inout.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD (writes), TURN (reads).
- IDLE:
  - Arbitrate with `a_req` priority.
  - `b_req` wins if `a_req`=0, or if the starve counter equals STARVE_MAX.
  - On a grant, latch the winner, address, data, byte enables (capture always uses 2'b11) and direction, then go to SETUP.
- Starve counter:
  - Increments on each capture grant while `b_req`=1.
  - Clears on a host grant or whenever `b_req`=0.
  - Saturates at STARVE_MAX.
- SETUP (1 cycle):
  - Address and selected `ncs` driven low.
  - For a write, data driven (`psram_data_oe`=1); strobes stay high.
- ACCESS (T_WR or T_RD cycles):
  - Write: `psram_nwe`=0.
  - Read: the selected chip's `noe`=0. `psram_data_i` is registered on the last ACCESS cycle's clock edge.
- HOLD (write, 1 cycle): `nwe`=1; `ncs`, address and data held; winner's ack pulses; next state IDLE.
- TURN (read, 1 cycle): `ncs`=1, `noe`=1, `data_oe`=0; `b_ack` pulses with `b_rdata` valid; next state IDLE. This guarantees bus turnaround before any write.
- Requesters hold req/addr/data stable until ack.
  - Keeping req high after ack starts a new transaction (re-arbitrated in IDLE).
  - Deasserting req before ack is illegal; behaviour is undefined.
- Only one chip is ever selected; `ncs0` and `ncs1` are never low simultaneously.
- Reset (asynchronous, also mid-transaction):
  - Immediately forces all `ncs`/`noe`/`nwe`/`nbyte_en` high, `data_oe`=0, acks 0, `busy`=0.
  - Clears `b_rdata`, `psram_address` and `psram_data_o` to 0, state to IDLE and starve counter to 0.
  - The aborted transaction is not acknowledged.

## Timing
- All outputs are registered; there is no combinational path from inputs to pads or acks.
- Write, request sampled in IDLE at cycle 0: SETUP 1, ACCESS 2..T_WR+1, HOLD with `a_ack`/`b_ack` at T_WR+2; next IDLE at T_WR+3. Defaults: ack at cycle 5, 6 cycles per write.
- Read: SETUP 1, ACCESS 2..T_RD+1, TURN with `b_ack` at T_RD+2; next IDLE at T_RD+3. Defaults: ack at cycle 6, 7 cycles per read.
- Address and `ncs` are stable from SETUP through HOLD (writes) or through ACCESS (reads).
- `nwe` rises one cycle before data is released.

## Structure
- Package `psram_pkg` holds:
  - the state enum (`psram_state_t`);
  - the winner encoding (`GNT_A`, `GNT_B`);
  - the default timing constants.
- One sub-module, `psram_wait_cnt`: a loadable down-counter with a terminal flag, shared by ACCESS for both directions.
- Arbitration and strobe generation stay in the parent.

## Test plan
- Reset: assert `MSS_RESET_N`=0 mid-ACCESS of a write → `nwe`, `ncs0`, `ncs1`, `noe0`, `noe1`=1, `data_oe`=0 and `busy`=0 within the same cycle, with no ack afterwards.
- Single capture write: `a_addr`=0x000010, data 0xBEEF → `ncs0` low for cycles 1..5, `nwe` low for cycles 2..4, `nbyte_en`=2'b00, `a_ack` at cycle 5.
- Host read on chip 1:
  - `b_addr`=0x400020, memory model returns 0x1234 → `ncs1` low and `noe1` low for cycles 2..5.
  - `noe0` stays high throughout.
  - `b_ack` at cycle 6 with `b_rdata`=0x1234.
- Host byte write: `b_be`=2'b10, data 0xAB00 → `nbyte_en`=2'b01 during SETUP..HOLD.
- Starvation: hold `a_req` and `b_req` high continuously → grant order A,A,A,A,B,A,A,A,A,B; the starve counter never exceeds 4.
- Read followed immediately by a capture write → TURN cycle with `data_oe`=0 and both `noe` high before the write's SETUP asserts `data_oe`.
